traffic_nway: RTL
=================

# traffic_nway

Parametrised N-approach traffic-light controller for intersections of 2..8 directions, with demand-actuated green phases. It serves one direction at a time through a fixed sequence: GREEN, YELLOW, then ALLRED. Phase durations are counted in prescaled ticks, and green is extended or skipped according to per-direction vehicle sensors. It sits between the intersection sensor inputs and the lamp drivers, and replaces the fixed two-road, fixed-timing controller.

## Interface
- NUM_DIR, 4, number of approaches (2..8)
- TICK_DIV, 100_000_000, clk cycles per timing tick (>=1)
- CNT_W, 8, phase counter width; must hold GREEN_MAX-1 and WALK_TICKS-1
- GREEN_MIN, 5, minimum green, in ticks (>=1)
- GREEN_MAX, 15, maximum green when competing demand exists (>=GREEN_MIN)
- YELLOW_TICKS, 2, yellow duration (>=1)
- ALLRED_TICKS, 1, all-red clearance (>=1)
- WALK_TICKS, 4, pedestrian walk duration (used only with TRAFFIC_PED_EN)
- clk  in  1  single clock
- rst  in  1  reset, synchronous, active-high
- car_present  in  NUM_DIR  level sensor; bit i is demand on direction i
- ped_req  in  1  pedestrian request pulse (present only with TRAFFIC_PED_EN)
- lights  out  3*NUM_DIR  lights[3i+2:3i] for direction i; one-hot encoding: 001 green, 010 yellow, 100 red
- active_dir  out  max(1,$clog2(NUM_DIR))  direction currently served
- phase  out  2  00 GREEN, 01 YELLOW, 10 ALLRED, 11 WALK
- ped_walk  out  1  high during WALK (present only with TRAFFIC_PED_EN)

## Operation
- Reset state: dir=0, phase=GREEN, count=0, prescaler=0, ped_pending=0.
  - Outputs after reset: lights = direction 0 green, all others red; active_dir=0; ped_walk=0.
- Prescaler: counts 0..TICK_DIV-1 and wraps. `tick` is high for one cycle when it reaches TICK_DIV-1.
- Phase counter: changes only on `tick`.
  - Non-final tick: count increments.
  - Final tick: phase advances and count is cleared to 0.
- other_demand = OR of car_present excluding bit dir, OR ped_pending.
- GREEN ends on the tick where all three hold:
  - count >= GREEN_MIN-1, and
  - other_demand = 1, and
  - car_present[dir] = 0 or count == GREEN_MAX-1.
- GREEN otherwise:
  - count increments, saturating at GREEN_MAX-1.
  - With no other demand, GREEN rests indefinitely.
- YELLOW ends on the tick with count == YELLOW_TICKS-1.
- ALLRED ends on the tick with count == ALLRED_TICKS-1.
- Next direction, chosen at the end of ALLRED:
  - Round-robin search dir+1, dir+2, … mod NUM_DIR; the first index with car_present set wins.
  - If no bit is set, dir is unchanged.
  - car_present is sampled in the same cycle as the transition.
- Light decode is pure combinational logic from the phase/dir registers:
  - Served direction shows green in GREEN and yellow in YELLOW.
  - Every other direction, and every direction in ALLRED/WALK, shows red.
- At any time exactly one light bit is set per direction.

## Timing
- A phase of D ticks lasts exactly D*TICK_DIV clk cycles. Lights change on the clk edge at which the final tick is registered.
- First GREEN after reset lasts GREEN_MIN*TICK_DIV cycles when demand is already present at reset.
- car_present has no latency beyond one register stage in the decision path, i.e. it is sampled on the deciding cycle.
- rst mid-phase: on the next edge, state returns to the reset state. The partial prescaler count and ped_pending are discarded.
- Simultaneous demand on several directions: lowest distance from dir+1 wins, wrapping past NUM_DIR-1 to 0.

## Configuration
- TRAFFIC_PED_EN defined: adds ped_req, ped_walk, the WALK phase and ped_pending.
  - ped_req sets ped_pending.
  - At the end of ALLRED, if ped_pending=1, the controller enters WALK (all red, ped_walk=1) for WALK_TICKS, then goes to GREEN of the round-robin direction.
  - ped_pending clears on WALK entry. A ped_req in the entry cycle is dropped; a ped_req during WALK is latched for the next cycle.
- TRAFFIC_PED_EN undefined:
  - No ped ports.
  - phase never equals 11.
  - other_demand is derived from car_present only.

## Structure
- Package traffic_pkg holds:
  - light encodings GREEN_L=3'b001, YELLOW_L=3'b010, RED_L=3'b100;
  - the phase enum (PH_GREEN, PH_YELLOW, PH_ALLRED, PH_WALK).
- Sub-module traffic_tick_gen: the TICK_DIV prescaler producing `tick`, with synchronous rst.
- The round-robin next-direction picker is a function in the main module.

## Test plan
Common setup: NUM_DIR=4, TICK_DIV=2, GREEN_MIN=3, GREEN_MAX=6, YELLOW_TICKS=2, ALLRED_TICKS=1.
- Rest in green: rst, then car_present=0 for 200 clk -> lights stays 12'b100_100_100_001, active_dir=0, phase=00 throughout.
- Basic cycle: car_present=4'b0100 from reset -> dir0 green 6 clk, yellow 4 clk, all-red 2 clk, then dir2 green (lights=12'b100_001_100_100).
- Max green: car_present=4'b0101 held -> dir0 green 12 clk (GREEN_MAX), then yellow, all-red, dir2 green; dir2 likewise terminates at 12 clk and returns to dir0.
- Wrap/skip: dir3 green, car_present=4'b0010 -> after all-red, active_dir=1 (dir0 skipped).
- Reset mid-operation: rst pulsed during YELLOW on dir2 -> next edge: phase=00, active_dir=0, dir0 green, full GREEN_MIN timing restarts.
- TRAFFIC_PED_EN, WALK_TICKS=4: one-cycle ped_req at clk 1 with car_present=0 -> dir0 green ends at 6 clk, yellow 4, all-red 2, WALK 8 clk with ped_walk=1 and all red, then dir0 green.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared lamp encodings and phase enumeration for the N-approach traffic controller.
package traffic_pkg;

  localparam logic [2:0] GREEN_L  = 3'b001;
  localparam logic [2:0] YELLOW_L = 3'b010;
  localparam logic [2:0] RED_L    = 3'b100;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'b00,
    PH_YELLOW = 2'b01,
    PH_ALLRED = 2'b10,
    PH_WALK   = 2'b11
  } phase_e;

endpackage

// File: rtl/traffic_tick_gen.sv
// Free-running TICK_DIV prescaler; tick_c is high for the last cycle of each period.
module traffic_tick_gen #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick_c
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] pre_q;

  assign tick_c = (pre_q == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
    end else if (tick_c) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + PW'(1);
    end
  end

endmodule

// File: rtl/traffic_nway.sv
// Demand-actuated N-approach traffic controller (GREEN -> YELLOW -> ALLRED, round-robin).
// Optional pedestrian WALK phase enabled by defining TRAFFIC_PED_EN.
module traffic_nway
  import traffic_pkg::*;
#(
  parameter int unsigned NUM_DIR      = 4,
  parameter int unsigned TICK_DIV     = 100_000_000,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned GREEN_MIN    = 5,
  parameter int unsigned GREEN_MAX    = 15,
  parameter int unsigned YELLOW_TICKS = 2,
  parameter int unsigned ALLRED_TICKS = 1,
  parameter int unsigned WALK_TICKS   = 4,
  localparam int unsigned DIR_W       = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_DIR-1:0]     car_present,
`ifdef TRAFFIC_PED_EN
  input  logic                   ped_req,
  output logic                   ped_walk,
`endif
  output logic [3*NUM_DIR-1:0]   lights,
  output logic [DIR_W-1:0]       active_dir,
  output logic [1:0]             phase
);

  phase_e             phase_q, phase_d;
  logic [DIR_W-1:0]   dir_q, dir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tick;
  logic               ped_pending;
  logic               other_demand;

  traffic_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .tick_c (tick)
  );

  // Nearest requesting direction after cur, wrapping; cur itself if nobody asks.
  function automatic logic [DIR_W-1:0] next_dir(input logic [DIR_W-1:0] cur,
                                                input logic [NUM_DIR-1:0] req);
    logic [DIR_W-1:0] sel;
    int unsigned      idx;
    sel = cur;
    for (int k = int'(NUM_DIR) - 1; k >= 1; k--) begin
      idx = (int'(cur) + k) % NUM_DIR;
      if (req[DIR_W'(idx)]) sel = DIR_W'(idx);
    end
    return sel;
  endfunction

  always_comb begin
    other_demand = ped_pending;
    for (int i = 0; i < int'(NUM_DIR); i++) begin
      if (DIR_W'(i) != dir_q && car_present[i]) other_demand = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_GREEN;
      dir_q   <= '0;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    if (tick) begin
      case (phase_q)
        PH_GREEN: begin
          if (cnt_q >= CNT_W'(GREEN_MIN - 1) && other_demand &&
              (!car_present[dir_q] || cnt_q == CNT_W'(GREEN_MAX - 1))) begin
            phase_d = PH_YELLOW;
            cnt_d   = '0;
          end else if (cnt_q != CNT_W'(GREEN_MAX - 1)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        PH_YELLOW: begin
          if (cnt_q == CNT_W'(YELLOW_TICKS - 1)) begin
            phase_d = PH_ALLRED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        PH_ALLRED: begin
          if (cnt_q == CNT_W'(ALLRED_TICKS - 1)) begin
            cnt_d = '0;
            if (ped_pending) begin
              phase_d = PH_WALK;
            end else begin
              phase_d = PH_GREEN;
              dir_d   = next_dir(dir_q, car_present);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        PH_WALK: begin
          if (cnt_q == CNT_W'(WALK_TICKS - 1)) begin
            phase_d = PH_GREEN;
            dir_d   = next_dir(dir_q, car_present);
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TRAFFIC_PED_EN
  logic ped_clr_c;

  // Entering WALK consumes the request; a request in that same cycle is dropped.
  assign ped_clr_c = (phase_d == PH_WALK) && (phase_q != PH_WALK);

  always_ff @(posedge clk) begin
    if (rst) begin
      ped_pending <= 1'b0;
    end else if (ped_clr_c) begin
      ped_pending <= 1'b0;
    end else if (ped_req) begin
      ped_pending <= 1'b1;
    end
  end

  assign ped_walk = (phase_q == PH_WALK);
`else
  assign ped_pending = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < int'(NUM_DIR); i++) begin
      lights[3*i +: 3] = RED_L;
      if (DIR_W'(i) == dir_q) begin
        if (phase_q == PH_GREEN)  lights[3*i +: 3] = GREEN_L;
        if (phase_q == PH_YELLOW) lights[3*i +: 3] = YELLOW_L;
      end
    end
  end

  assign active_dir = dir_q;
  assign phase      = phase_q;

endmodule
